pwm_breath_seq: RTL and testbench

- Sequencer that time-shares one PWM period counter and comparator across NUM_CH LED channels.
- Breathes one channel at a time: ramp up, hold bright, ramp down, hold dark. Then advances to the next channel in a chase.
- Sits between the board key/control logic (start/stop pulses) and the LED pins.
- Replaces per-LED free-running breathing logic with one scheduled resource.

---
 rtl/pwm_breath_seq.sv | 181 ++++++++++++++++++
 tb/tb_pwm_breath_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_seq.sv
// Breathing-LED sequencer: one shared PWM period counter/comparator is scheduled across NUM_CH channels in a chase.
// Define PWM_BREATH_SEQ_BOUNCE_EN for ping-pong channel order; the default is wrap order.
//
// state     | meaning
// ----------+-------------------------------------------
// S_IDLE    | no sequence running, all LEDs dark
// S_UP      | duty rises by STEP each PWM period
// S_HOLD_HI | duty held at PERIOD for HOLD_PERIODS periods
// S_DOWN    | duty falls by STEP each PWM period
// S_HOLD_LO | duty held at 0, then next channel or stop
module pwm_breath_seq #(
    parameter int PERIOD       = 50000,
    parameter int STEP         = 25,
    parameter int HOLD_PERIODS = 100,
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [NUM_CH-1:0] led,
    output logic [CH_W-1:0]   chan_sel,
    output logic [15:0]       duty_cycle,
    output logic              busy,
    output logic              seq_done
);

    localparam logic [15:0] PER    = 16'(PERIOD);
    localparam logic [15:0] PER_M1 = 16'(PERIOD - 1);
    localparam logic [15:0] STP    = 16'(STEP);
    localparam logic [15:0] SAT_UP = 16'(PERIOD - STEP);
    localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_HOLD_HI,
        S_DOWN,
        S_HOLD_LO
    } state_t;

    state_t state, state_nxt;
    logic [15:0] period_cnt, duty_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [CH_W-1:0] chan_nxt;
    logic [NUM_CH-1:0] led_nxt;
    logic stop_pend, stop_pend_nxt, done_nxt, tick, pwm_on;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
    logic dir_down, dir_down_nxt;
`endif

    assign tick   = (period_cnt == PER_M1);
    assign pwm_on = (state != S_IDLE) && (period_cnt < duty_cycle);

    always_comb begin
        state_nxt     = state;
        duty_nxt      = duty_cycle;
        hold_nxt      = hold_cnt;
        chan_nxt      = chan_sel;
        stop_pend_nxt = stop_pend;
        done_nxt      = 1'b0;
        led_nxt       = '0;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
        dir_down_nxt  = dir_down;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            led_nxt[i] = pwm_on && (chan_sel == CH_W'(i));
        end
        if (state != S_IDLE && stop) begin
            stop_pend_nxt = 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt     = S_UP;
                    duty_nxt      = '0;
                    chan_nxt      = '0;
                    hold_nxt      = '0;
                    stop_pend_nxt = stop;
                end
            end
            S_UP: begin
                if (tick) begin
                    // saturate before adding so duty never passes PERIOD
                    if (duty_cycle >= SAT_UP) begin
                        duty_nxt  = PER;
                        state_nxt = S_HOLD_HI;
                    end else begin
                        duty_nxt = duty_cycle + STP;
                    end
                end
            end
            S_HOLD_HI: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt  = '0;
                        state_nxt = S_DOWN;
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            S_DOWN: begin
                if (tick) begin
                    if (duty_cycle <= STP) begin
                        duty_nxt  = '0;
                        state_nxt = S_HOLD_LO;
                    end else begin
                        duty_nxt = duty_cycle - STP;
                    end
                end
            end
            S_HOLD_LO: begin
                if (tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nxt = '0;
                        if (stop_pend) begin
                            state_nxt     = S_IDLE;
                            stop_pend_nxt = 1'b0;
                            done_nxt      = 1'b1;
                            chan_nxt      = '0;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
                            dir_down_nxt  = 1'b0;
`endif
                        end else begin
                            state_nxt = S_UP;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
                            if (!dir_down) begin
                                chan_nxt = chan_sel + CH_W'(1);
                                if (chan_sel + CH_W'(1) == CH_LAST) dir_down_nxt = 1'b1;
                            end else begin
                                chan_nxt = chan_sel - CH_W'(1);
                                if (chan_sel - CH_W'(1) == '0) dir_down_nxt = 1'b0;
                            end
`else
                            chan_nxt = (chan_sel == CH_LAST) ? '0 : chan_sel + CH_W'(1);
`endif
                        end
                    end else begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= S_IDLE;
            period_cnt <= '0;
            duty_cycle <= '0;
            chan_sel   <= '0;
            hold_cnt   <= '0;
            stop_pend  <= 1'b0;
            led        <= '0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
            dir_down   <= 1'b0;
`endif
        end else begin
            period_cnt <= tick ? '0 : period_cnt + 16'd1;
            state      <= state_nxt;
            duty_cycle <= duty_nxt;
            chan_sel   <= chan_nxt;
            hold_cnt   <= hold_nxt;
            stop_pend  <= stop_pend_nxt;
            led        <= led_nxt;
            busy       <= (state_nxt != S_IDLE);
            seq_done   <= done_nxt;
`ifdef PWM_BREATH_SEQ_BOUNCE_EN
            dir_down   <= dir_down_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_breath_seq.sv
// Directed testbench for pwm_breath_seq: PERIOD=10/STEP=5/HOLD=2/NUM_CH=3 main instance,
// plus a PERIOD=12 instance for the saturation case.
module tb_pwm_breath_seq;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic [2:0] led, led2;
    logic [1:0] chan_sel, chan_sel2;
    logic [15:0] duty_cycle, duty_cycle2;
    logic busy, busy2, seq_done, seq_done2;

    int total = 0;
    int bad = 0;
    int pc = 0;
    int pc2 = 0;
    int done_cnt = 0;
    int exp_duty[8] = '{5, 10, 10, 10, 5, 0, 0, 0};
    int exp_sat[10] = '{5, 10, 12, 12, 12, 7, 2, 0, 0, 0};

    pwm_breath_seq #(.PERIOD(10), .STEP(5), .HOLD_PERIODS(2), .NUM_CH(3), .CH_W(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
        .led(led), .chan_sel(chan_sel), .duty_cycle(duty_cycle), .busy(busy), .seq_done(seq_done));

    pwm_breath_seq #(.PERIOD(12), .STEP(5), .HOLD_PERIODS(2), .NUM_CH(3), .CH_W(2)) dut_sat (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .stop(stop2),
        .led(led2), .chan_sel(chan_sel2), .duty_cycle(duty_cycle2), .busy(busy2), .seq_done(seq_done2));

    always #5 sys_clk = ~sys_clk;

    // reference period counters: pc==0 at a falling edge means a tick edge just happened
    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pc  <= 0;
            pc2 <= 0;
        end else begin
            pc  <= (pc == 9) ? 0 : pc + 1;
            pc2 <= (pc2 == 11) ? 0 : pc2 + 1;
        end
    end

    always @(posedge sys_clk) begin
        #2;
        if (seq_done === 1'b1) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_tick();
        int g = 0;
        do begin
            @(negedge sys_clk);
            g++;
        end while (pc != 0 && g < 20);
    endtask

    task automatic next_tick2();
        int g = 0;
        do begin
            @(negedge sys_clk);
            g++;
        end while (pc2 != 0 && g < 20);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge sys_clk);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({led, busy, seq_done, chan_sel, duty_cycle} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {led, busy, seq_done, chan_sel, duty_cycle});
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            total++;
            if ({led, busy, seq_done, chan_sel, duty_cycle, led2, busy2, duty_cycle2} !== '0) begin
                bad++;
                $display("FAIL idle_outputs: got %h want 0",
                         {led, busy, seq_done, chan_sel, duty_cycle, led2, busy2, duty_cycle2});
            end
        end
    endtask

    task automatic test_single_ramp();
        int cnt, other, want;
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ramp_busy: got %0b want 1", busy);
        end
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            total++;
            if (duty_cycle !== 16'(exp_duty[k-1])) begin
                bad++;
                $display("FAIL ramp_duty tick%0d: got %0d want %0d", k, duty_cycle, exp_duty[k-1]);
            end
            total++;
            if (chan_sel !== ((k == 8) ? 2'd1 : 2'd0)) begin
                bad++;
                $display("FAIL ramp_chan tick%0d: got %0d want %0d", k, chan_sel, (k == 8) ? 1 : 0);
            end
            if (k == 1 || k == 3 || k == 6) begin
                want = (k == 1) ? 5 : (k == 3) ? 10 : 0;
                cnt = 0;
                other = 0;
                for (int i = 0; i < 10; i++) begin
                    cnt += int'(led[0]);
                    if (led[2:1] !== 2'b00) other++;
                    if (i < 9) @(negedge sys_clk);
                end
                total++;
                if (cnt != want) begin
                    bad++;
                    $display("FAIL ramp_led_high tick%0d: got %0d want %0d", k, cnt, want);
                end
                total++;
                if (other != 0) begin
                    bad++;
                    $display("FAIL ramp_led_other tick%0d: got %0d want 0", k, other);
                end
            end
        end
    endtask

    task automatic test_chase_wrap();
        int c, cnt, other;
        logic [2:0] one, mask;
        one = 3'b001;
        for (int k = 9; k <= 32; k++) begin
            next_tick();
            c = (k / 8) % 3;
            total++;
            if (duty_cycle !== 16'(exp_duty[(k-1)%8]) || chan_sel !== 2'(c) || busy !== 1'b1) begin
                bad++;
                $display("FAIL chase tick%0d: got duty=%0d chan=%0d busy=%0b want duty=%0d chan=%0d busy=1",
                         k, duty_cycle, chan_sel, busy, exp_duty[(k-1)%8], c);
            end
            if ((k - 1) % 8 == 0) begin
                mask = ~(one << c);
                cnt = 0;
                other = 0;
                for (int i = 0; i < 10; i++) begin
                    cnt += int'(led[c]);
                    if ((led & mask) !== 3'b000) other++;
                    if (i < 9) @(negedge sys_clk);
                end
                total++;
                if (cnt != 5 || other != 0) begin
                    bad++;
                    $display("FAIL chase_led ch%0d: got high=%0d other=%0d want high=5 other=0", c, cnt, other);
                end
            end
        end
    endtask

    task automatic test_graceful_stop();
        int base;
        base = done_cnt;
        pulse_stop();
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            if (k < 8) begin
                total++;
                if (duty_cycle !== 16'(exp_duty[k-1]) || chan_sel !== 2'd1 || busy !== 1'b1 || seq_done !== 1'b0) begin
                    bad++;
                    $display("FAIL stop_run tick%0d: got duty=%0d chan=%0d busy=%0b done=%0b want duty=%0d chan=1 busy=1 done=0",
                             k, duty_cycle, chan_sel, busy, seq_done, exp_duty[k-1]);
                end
                if (k == 5) pulse_stop();
            end else begin
                total++;
                if ({seq_done, busy, chan_sel, led, duty_cycle} !== {1'b1, 1'b0, 2'd0, 3'd0, 16'd0}) begin
                    bad++;
                    $display("FAIL stop_end: got done=%0b busy=%0b chan=%0d led=%b duty=%0d want 1 0 0 000 0",
                             seq_done, busy, chan_sel, led, duty_cycle);
                end
            end
        end
        @(negedge sys_clk);
        total++;
        if (seq_done !== 1'b0) begin
            bad++;
            $display("FAIL stop_done_width: got %0b want 0", seq_done);
        end
        repeat (25) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0 || done_cnt != base + 1) begin
            bad++;
            $display("FAIL stop_idle: got busy=%0b pulses=%0d want busy=0 pulses=%0d", busy, done_cnt - base, 1);
        end
    endtask

    task automatic test_start_stop_same();
        int base;
        base = done_cnt;
        repeat (3) @(negedge sys_clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        stop = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL same_busy: got %0b want 1", busy);
        end
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            total++;
            if (duty_cycle !== 16'(exp_duty[k-1]) || chan_sel !== 2'd0 || busy !== (k < 8)) begin
                bad++;
                $display("FAIL same tick%0d: got duty=%0d chan=%0d busy=%0b want duty=%0d chan=0 busy=%0b",
                         k, duty_cycle, chan_sel, busy, exp_duty[k-1], k < 8);
            end
            if (k == 5) pulse_start();
        end
        total++;
        if (seq_done !== 1'b1 || done_cnt != base + 1) begin
            bad++;
            $display("FAIL same_done: got done=%0b pulses=%0d want 1 1", seq_done, done_cnt - base);
        end
    endtask

    task automatic test_stop_in_idle();
        pulse_stop();
        repeat (4) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_stop_busy: got %0b want 0", busy);
        end
        pulse_start();
        repeat (8) next_tick();
        total++;
        if (busy !== 1'b1 || chan_sel !== 2'd1) begin
            bad++;
            $display("FAIL idle_stop_ignored: got busy=%0b chan=%0d want busy=1 chan=1", busy, chan_sel);
        end
        pulse_stop();
        repeat (8) next_tick();
        total++;
        if (busy !== 1'b0 || seq_done !== 1'b1 || chan_sel !== 2'd0) begin
            bad++;
            $display("FAIL idle_stop_end: got busy=%0b done=%0b chan=%0d want 0 1 0", busy, seq_done, chan_sel);
        end
    endtask

    task automatic test_saturation();
        int cnt;
        start2 = 1'b1;
        stop2 = 1'b1;
        @(negedge sys_clk);
        start2 = 1'b0;
        stop2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            next_tick2();
            total++;
            if (duty_cycle2 !== 16'(exp_sat[k-1])) begin
                bad++;
                $display("FAIL sat_duty tick%0d: got %0d want %0d", k, duty_cycle2, exp_sat[k-1]);
            end
            if (k == 6) begin
                cnt = 0;
                for (int i = 1; i < 12; i++) begin
                    @(negedge sys_clk);
                    cnt += int'(led2[0]);
                end
                total++;
                if (cnt != 7) begin
                    bad++;
                    $display("FAIL sat_led_high: got %0d want 7", cnt);
                end
            end
        end
        total++;
        if (busy2 !== 1'b0 || seq_done2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_end: got busy=%0b done=%0b want 0 1", busy2, seq_done2);
        end
    endtask

    task automatic test_reset_mid_down();
        int base;
        base = done_cnt;
        pulse_start();
        repeat (13) next_tick();
        total++;
        if (chan_sel !== 2'd1 || duty_cycle !== 16'd5) begin
            bad++;
            $display("FAIL rst_pre: got chan=%0d duty=%0d want chan=1 duty=5", chan_sel, duty_cycle);
        end
        repeat (2) @(negedge sys_clk);
        total++;
        if (led !== 3'b010) begin
            bad++;
            $display("FAIL rst_pre_led: got %b want 010", led);
        end
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        total++;
        if ({led, busy, seq_done, chan_sel, duty_cycle} !== 23'd0) begin
            bad++;
            $display("FAIL rst_mid: got %h want 0", {led, busy, seq_done, chan_sel, duty_cycle});
        end
        sys_rst_n = 1'b1;
        repeat (30) @(negedge sys_clk);
        total++;
        if (busy !== 1'b0 || led !== 3'b000 || done_cnt != base) begin
            bad++;
            $display("FAIL rst_after: got busy=%0b led=%b pulses=%0d want 0 000 0", busy, led, done_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_single_ramp();
        test_chase_wrap();
        test_graceful_stop();
        test_start_stop_same();
        test_stop_in_idle();
        test_saturation();
        test_reset_mid_down();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
